// File: rtl/tcp_malloc_arb_pkg.sv
// Shared helpers and types for the tcp_malloc request arbiter.
package tcp_malloc_arb_pkg;

  localparam int unsigned MAX_ID_W = 4;

  function automatic int unsigned id_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_outst);
    return $clog2(max_outst) + 1;
  endfunction

  // Tag FIFO entry: requester ID of an issued malloc, widest supported size.
  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
  } tag_entry_t;

endpackage

// File: rtl/fifo_1r1w.sv
// Single-read single-write synchronous FIFO, valid/ready on both sides, no bypass.
module fifo_1r1w #(
  parameter int unsigned width    = 8,
  parameter int unsigned log2_els = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enq_val,
  input  logic [width-1:0] enq_data,
  output logic             enq_rdy,
  output logic             deq_val,
  output logic [width-1:0] deq_data,
  input  logic             deq_rdy
);

  localparam int unsigned DEPTH = 1 << log2_els;

  logic [width-1:0]  mem [DEPTH];
  logic [log2_els:0] wr_ptr;
  logic [log2_els:0] rd_ptr;
  logic              full;
  logic              empty;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[log2_els] != rd_ptr[log2_els]) &&
                    (wr_ptr[log2_els-1:0] == rd_ptr[log2_els-1:0]);
  assign enq_rdy  = !full;
  assign deq_val  = !empty;
  assign deq_data = mem[rd_ptr[log2_els-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq_val && enq_rdy) wr_ptr <= wr_ptr + 1'b1;
      if (deq_rdy && deq_val) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_val && enq_rdy) mem[wr_ptr[log2_els-1:0]] <= enq_data;
  end

endmodule

// File: rtl/tcp_malloc_arbiter_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; pointer moves past the winner on advance.
module rr_arbiter
  import tcp_malloc_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any
);

  logic [ID_W-1:0] ptr;
  int unsigned     k;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    k       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = {{(32-ID_W){1'b0}}, ptr} + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!any && req[k[ID_W-1:0]]) begin
        any                = 1'b1;
        gnt_idx            = k[ID_W-1:0];
        gnt[k[ID_W-1:0]]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/tcp_malloc_arbiter.sv
// Shares one tcp_malloc allocator among NUM_REQ clients; responses are routed back
// in issue order through a tag FIFO, and per-client outstanding mallocs are capped.
module tcp_malloc_arbiter
  import tcp_malloc_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned PTR_W     = 16,
  parameter int unsigned LEN_W     = 11,
  parameter int unsigned TAG_LOG2  = 2,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_REQ-1:0]                      cl_malloc_req_val,
  input  logic [NUM_REQ*LEN_W-1:0]                cl_malloc_req_len,
  output logic [NUM_REQ-1:0]                      cl_malloc_req_rdy,
  output logic [NUM_REQ-1:0]                      cl_malloc_resp_val,
  output logic                                    cl_malloc_resp_success,
  output logic [PTR_W-1:0]                        cl_malloc_resp_addr,
  input  logic [NUM_REQ-1:0]                      cl_malloc_resp_rdy,
  input  logic [NUM_REQ-1:0]                      cl_free_req_val,
  input  logic [NUM_REQ*PTR_W-1:0]                cl_free_req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]                cl_free_req_len,
  output logic [NUM_REQ-1:0]                      cl_free_req_rdy,
  output logic                                    al_malloc_req_val,
  output logic [LEN_W-1:0]                        al_malloc_req_len,
  input  logic                                    al_malloc_req_rdy,
  input  logic                                    al_malloc_resp_val,
  input  logic                                    al_malloc_resp_success,
  input  logic [PTR_W-1:0]                        al_malloc_resp_addr,
  output logic                                    al_malloc_resp_rdy,
  output logic                                    al_free_req_val,
  output logic [PTR_W-1:0]                        al_free_req_addr,
  output logic [LEN_W-1:0]                        al_free_req_len,
  input  logic                                    al_free_req_rdy,
  output logic [NUM_REQ*cnt_width(MAX_OUTST)-1:0] outst_cnt
);

  localparam int unsigned ID_W  = id_width(NUM_REQ);
  localparam int unsigned CNT_W = cnt_width(MAX_OUTST);

  logic               run;
  logic [CNT_W-1:0]   cnt [NUM_REQ];
  logic [NUM_REQ-1:0] m_elig, m_gnt, f_req, f_gnt;
  logic [NUM_REQ-1:0] cnt_inc, cnt_dec;
  logic [ID_W-1:0]    m_idx, f_idx, head_raw, head;
  logic               m_any, f_any;
  logic               tag_not_full, tag_not_empty;
  logic               m_hs, r_hs, f_hs;
  tag_entry_t         head_entry;

  // Outputs stay quiet until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  always_comb begin
    m_elig = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      m_elig[i] = run && cl_malloc_req_val[i] && (cnt[i] < CNT_W'(MAX_OUTST));
    end
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_malloc_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (m_elig),
    .adv     (m_hs),
    .gnt     (m_gnt),
    .gnt_idx (m_idx),
    .any     (m_any)
  );

  assign al_malloc_req_val = m_any && tag_not_full;
  assign al_malloc_req_len = cl_malloc_req_len[m_idx*LEN_W +: LEN_W];
  assign m_hs              = al_malloc_req_val && al_malloc_req_rdy;
  assign cl_malloc_req_rdy = m_hs ? m_gnt : '0;

  fifo_1r1w #(.width(ID_W), .log2_els(TAG_LOG2)) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .enq_val  (m_hs),
    .enq_data (m_idx),
    .enq_rdy  (tag_not_full),
    .deq_val  (tag_not_empty),
    .deq_data (head_raw),
    .deq_rdy  (r_hs)
  );

  always_comb begin
    head_entry              = '0;
    head_entry.id[ID_W-1:0] = head_raw;
  end
  assign head = head_entry.id[ID_W-1:0];

  always_comb begin
    cl_malloc_resp_val = '0;
    if (al_malloc_resp_val && tag_not_empty) cl_malloc_resp_val[head] = 1'b1;
  end

  assign cl_malloc_resp_success = al_malloc_resp_success;
  assign cl_malloc_resp_addr    = al_malloc_resp_addr;
  assign al_malloc_resp_rdy     = tag_not_empty && cl_malloc_resp_rdy[head];
  assign r_hs                   = al_malloc_resp_val && al_malloc_resp_rdy;

  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cnt_inc[i] = m_hs && (m_idx == ID_W'(i));
      cnt_dec[i] = r_hs && (head == ID_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        case ({cnt_inc[i], cnt_dec[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  always_comb begin
    outst_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) outst_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end

  assign f_req = run ? cl_free_req_val : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_free_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (f_req),
    .adv     (f_hs),
    .gnt     (f_gnt),
    .gnt_idx (f_idx),
    .any     (f_any)
  );

  assign al_free_req_val  = f_any;
  assign al_free_req_addr = cl_free_req_addr[f_idx*PTR_W +: PTR_W];
  assign al_free_req_len  = cl_free_req_len[f_idx*LEN_W +: LEN_W];
  assign f_hs             = f_any && al_free_req_rdy;
  assign cl_free_req_rdy  = f_hs ? f_gnt : '0;

  orphan_resp_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(run && al_malloc_resp_val && !tag_not_empty))
    else $error("orphan allocator response with empty tag FIFO");

  cnt_underflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_hs && (cnt[head] == '0)))
    else $error("outstanding count underflow");

endmodule

// File: doc/tcp_malloc_arbiter.md
Name: tcp_malloc_arbiter

Overview:
- Shares one tcp_malloc allocator among NUM_REQ requesters, e.g. per-direction TCP engines and the RX/TX buffer managers.
- Arbitrates malloc and free requests with independent round-robin pointers.
- Tags each issued malloc with the requester ID in an in-order tag FIFO, and uses it to route allocator responses back to the right requester.
- Caps each requester's outstanding mallocs so one client cannot monopolise the allocator.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- PTR_W, 16, allocator address width.
- LEN_W, 11, allocator length width.
- TAG_LOG2, 2, log2 depth of the response-routing tag FIFO.
- MAX_OUTST, 2, maximum outstanding mallocs per requester (1..2^TAG_LOG2).
- ID_W, $clog2(NUM_REQ), generated, requester ID width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cl_malloc_req_val  in  NUM_REQ  per-requester malloc request valid.
- cl_malloc_req_len  in  NUM_REQ*LEN_W  per-requester length; slice i is [i*LEN_W +: LEN_W].
- cl_malloc_req_rdy  out  NUM_REQ  accept strobe to requester.
- cl_malloc_resp_val  out  NUM_REQ  response valid to requester.
- cl_malloc_resp_success  out  1  shared; qualified by the requester's resp_val.
- cl_malloc_resp_addr  out  PTR_W  shared; qualified by the requester's resp_val.
- cl_malloc_resp_rdy  in  NUM_REQ  requester ready for response.
- cl_free_req_val  in  NUM_REQ  free request valid.
- cl_free_req_addr  in  NUM_REQ*PTR_W  free address, packed like len.
- cl_free_req_len  in  NUM_REQ*LEN_W  free length, packed.
- cl_free_req_rdy  out  NUM_REQ  free accept.
- al_malloc_req_val / al_malloc_req_len / al_malloc_req_rdy  out/out/in  1/LEN_W/1  to allocator.
- al_malloc_resp_val / al_malloc_resp_success / al_malloc_resp_addr / al_malloc_resp_rdy  in/in/in/out  1/1/PTR_W/1  from allocator.
- al_free_req_val / al_free_req_addr / al_free_req_len / al_free_req_rdy  out/out/out/in  1/PTR_W/LEN_W/1  to allocator.
- outst_cnt  out  NUM_REQ*($clog2(MAX_OUTST)+1)  per-requester outstanding count, for debug/status.

Behaviour:
- Reset: while rst_n=0 and on the first clk edge after release:
  - all *_rdy and *_val outputs are 0;
  - malloc and free RR pointers are 0 (requester 0 has top priority);
  - tag FIFO is empty; all outst_cnt are 0.
- Reset is asynchronous assert, synchronous deassert (external synchroniser), and aborts all in-flight state.
- Responses still in flight in the allocator after a reset are dropped: al_malloc_resp_rdy=0 until reset ends, then the block treats them as orphans (see below). The integration rule is to reset the allocator together with this block.
- Malloc eligibility: requester i is eligible when cl_malloc_req_val[i]=1 and outst_cnt[i] < MAX_OUTST.
- Malloc grant:
  - grant = first eligible index at or after the malloc pointer, wrapping modulo NUM_REQ;
  - al_malloc_req_val = any eligible AND tag FIFO not full;
  - al_malloc_req_len = granted requester's slice;
  - cl_malloc_req_rdy[g] = al_malloc_req_val AND al_malloc_req_rdy; all other bits are 0.
  - The path is combinational, zero added latency.
- On a malloc handshake:
  - push g into the tag FIFO;
  - outst_cnt[g] += 1;
  - malloc pointer <= (g+1) mod NUM_REQ.
- With no handshake, the pointer holds. A stalled grant is not re-arbitrated away unless that requester drops val, which is illegal: val must hold until rdy.
- Tag FIFO full blocks new issue, even if a pop happens in the same cycle (no bypass).
- Response routing:
  - h = tag FIFO head;
  - cl_malloc_resp_val[h] = al_malloc_resp_val AND tag FIFO not empty; other bits are 0;
  - success/addr pass through combinationally;
  - al_malloc_resp_rdy = cl_malloc_resp_rdy[h] AND tag FIFO not empty.
- On a response handshake: pop the tag FIFO; outst_cnt[h] -= 1.
- Same-cycle issue and response for one requester leaves its count unchanged. Same-cycle push and pop on a non-full FIFO is legal.
- An allocator response while the tag FIFO is empty is not accepted (rdy=0). Simulation flags it with $error as an orphan.
- A failed response (success=0) still decrements the count; the requester retries.
- Free path: independent RR pointer with identical grant and pointer-advance rules, but no tag and no count.
  - al_free_req_val = any cl_free_req_val;
  - addr/len muxed from the granted requester;
  - cl_free_req_rdy[g] = al_free_req_rdy.
- Malloc and free paths may both handshake in the same cycle.
- Widths: outst_cnt saturation can never occur because of the eligibility mask. Simulation asserts no underflow.

Decomposition:
- Package tcp_malloc_arb_pkg: ID_W helper function, the outst_cnt width function, and a typedef for the packed tag-FIFO entry.
- Sub-module rr_arbiter (parameter NUM_REQ): request vector plus advance strobe in, one-hot/index grant out, internal pointer. Instantiated twice, once for malloc and once for free.
- Tag FIFO uses the codebase's existing fifo_1r1w (width ID_W, log2_els TAG_LOG2).

Test Plan:
- Reset/idle: rst_n low for 3 cycles with all vals high → all rdy/val outputs are 0 during reset; first grant after release goes to requester 0.
- Round-robin fairness: NUM_REQ=4, all four malloc vals held, allocator always ready and responding after 1 cycle → grants 0,1,2,3,0…; each requester receives its own addr (0x000, 0x800, 0x1000, 0x1800 with LEN_MAX=2048).
- Outstanding cap: MAX_OUTST=2, requester 2 only, allocator resp_val held low → two handshakes, then cl_malloc_req_rdy[2]=0 and outst_cnt[2]=2. Releasing one response brings the count to 1 and the third request issues next cycle.
- Routing under backpressure: issue from requesters 1 then 3; hold cl_malloc_resp_rdy[1]=0 for 5 cycles → requester 3's response is not delivered (in-order head blocking); after rdy[1] rises, 1 then 3 receive their addrs in consecutive cycles.
- Failure passthrough: allocator returns success=0 → the requester sees resp_val with success=0, its count decrements, and a retry is granted.
- Concurrent free and malloc, plus tag-full: requesters 0 and 3 free while 1 mallocs with the tag FIFO filled to 4 → frees alternate 0,3 unaffected; the malloc stalls until the first pop, then issues the following cycle.
